// File: rtl/dlatch_sync.sv
// -----------------------------------------------------------------------------
// dlatch_sync
//
// Enable-gated D storage element. It behaves like a classic D latch but is
// built entirely from rising-edge logic in a single clock domain, so timing
// analysis sees an ordinary register.
//
// Two output styles, selected at elaboration by TRANSPARENT:
//   0 : edge-captured. q is the register, so d reaches q one edge later.
//   1 : latch-style. q follows d combinationally while en=1, and shows the
//       stored value while en=0. A reset forces q to RESET_VALUE at once.
//
// Parameters:
//   WIDTH        data width of d, q and qbar
//   RESET_VALUE  value loaded into storage on reset
//   TRANSPARENT  0 = edge-captured output, 1 = latch-style output
//
// Ports:
//   clk      system clock; all state changes happen on its rising edge
//   rst      synchronous reset, active-high; has priority over en
//   en       capture enable (and bypass enable when TRANSPARENT=1)
//   d        data in
//   q        stored data, or bypassed data in latch-style mode
//   qbar     bitwise inverse of q
//   changed  registered one-cycle pulse, high when the last edge altered
//            the stored value
// -----------------------------------------------------------------------------
module dlatch_sync #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter bit               TRANSPARENT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             changed
);

  // The only state in the block: the held data word.
  logic [WIDTH-1:0] store;

  // Storage and change-detect register.
  // NOTE: sequential state uses non-blocking assignments. The comparison
  // d != store therefore sees the value held before this edge, which is
  // exactly what the change pulse needs to describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      store   <= RESET_VALUE;
      changed <= 1'b0;
    end else if (en) begin
      store   <= d;
      changed <= (d != store);
    end else begin
      changed <= 1'b0;
    end
  end

  // Output selection.
  generate
    if (TRANSPARENT) begin : g_transparent
      // NOTE: the bypass is a fully specified continuous mux, so every input
      // combination produces a value and no latch is inferred. The "hold"
      // half of the latch behaviour comes from the register above.
      assign q = rst ? RESET_VALUE : (en ? d : store);
    end else begin : g_registered
      assign q = store;
    end
  endgenerate

  assign qbar = ~q;

endmodule

// File: tb/tb_dlatch_sync.sv
// -----------------------------------------------------------------------------
// tb_dlatch_sync
//
// Directed bench for dlatch_sync. Three instances share one clock:
//   u_bit  : WIDTH=1, RESET_VALUE=0, edge-captured
//   u_tr   : WIDTH=8, RESET_VALUE=0, latch-style (TRANSPARENT=1)
//   u_wide : WIDTH=8, RESET_VALUE=8'h5A, edge-captured
// Each instance has its own rst/en/d so the scenarios stay independent.
// Inputs change and outputs are sampled 1 time unit after a rising edge.
// -----------------------------------------------------------------------------
module tb_dlatch_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // u_bit
  logic       rst_b, en_b;
  logic [0:0] d_b, q_b, qbar_b;
  logic       chg_b;

  // u_tr
  logic       rst_t, en_t;
  logic [7:0] d_t, q_t, qbar_t;
  logic       chg_t;

  // u_wide
  logic       rst_w, en_w;
  logic [7:0] d_w, q_w, qbar_w;
  logic       chg_w;

  dlatch_sync #(.WIDTH(1), .RESET_VALUE(1'b0), .TRANSPARENT(1'b0)) u_bit (
    .clk(clk), .rst(rst_b), .en(en_b), .d(d_b),
    .q(q_b), .qbar(qbar_b), .changed(chg_b)
  );

  dlatch_sync #(.WIDTH(8), .RESET_VALUE(8'h00), .TRANSPARENT(1'b1)) u_tr (
    .clk(clk), .rst(rst_t), .en(en_t), .d(d_t),
    .q(q_t), .qbar(qbar_t), .changed(chg_t)
  );

  dlatch_sync #(.WIDTH(8), .RESET_VALUE(8'h5A), .TRANSPARENT(1'b0)) u_wide (
    .clk(clk), .rst(rst_w), .en(en_w), .d(d_w),
    .q(q_w), .qbar(qbar_w), .changed(chg_w)
  );

  int checks   = 0;
  int failures = 0;

  // Four-state compare, so an X on any output counts as a mismatch.
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_b = 1'b0; en_b = 1'b0; d_b = 1'b0;
    rst_t = 1'b0; en_t = 1'b0; d_t = 8'h00;
    rst_w = 1'b0; en_w = 1'b0; d_w = 8'h00;
    #2;

    // ---------------- u_bit: WIDTH=1, edge-captured ----------------
    // Reset beats enable.
    rst_b = 1'b1; en_b = 1'b1; d_b = 1'b1;
    tick();
    check("bit_rst_q",    q_b,    8'h00);
    check("bit_rst_qbar", qbar_b, 8'h01);
    check("bit_rst_chg",  chg_b,  8'h00);

    // Capture 1: store goes 0 -> 1.
    rst_b = 1'b0; en_b = 1'b1; d_b = 1'b1;
    tick();
    check("bit_cap1_q",    q_b,    8'h01);
    check("bit_cap1_qbar", qbar_b, 8'h00);
    check("bit_cap1_chg",  chg_b,  8'h01);

    // Capture 0: store goes 1 -> 0.
    d_b = 1'b0;
    tick();
    check("bit_cap0_q",   q_b,   8'h00);
    check("bit_cap0_chg", chg_b, 8'h01);

    // Hold across three edges while d toggles 1/0/1.
    en_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d_b = (i % 2 == 0) ? 1'b1 : 1'b0;
      tick();
      check($sformatf("bit_hold%0d_q", i),   q_b,   8'h00);
      check($sformatf("bit_hold%0d_chg", i), chg_b, 8'h00);
    end

    // Capture of an unchanged value gives no change pulse.
    en_b = 1'b1; d_b = 1'b0;
    tick();
    check("bit_same_q",   q_b,   8'h00);
    check("bit_same_chg", chg_b, 8'h00);

    // Mid-operation reset with en=1, d=1 after storing 1.
    d_b = 1'b1;
    tick();
    check("bit_pre_rst_q", q_b, 8'h01);
    rst_b = 1'b1;
    #1;
    check("bit_rst_nobypass_q", q_b, 8'h01);  // registered mode: no immediate effect
    tick();
    check("bit_midrst_q",   q_b,   8'h00);
    check("bit_midrst_chg", chg_b, 8'h00);
    rst_b = 1'b0; en_b = 1'b0;

    // ---------------- u_tr: WIDTH=8, transparent ----------------
    // Reset shows combinationally, before any edge.
    rst_t = 1'b1; en_t = 1'b1; d_t = 8'hEE;
    #1;
    check("tr_rst_comb_q",    q_t,    8'h00);
    check("tr_rst_comb_qbar", qbar_t, 8'hFF);
    tick();
    check("tr_rst_edge_q",   q_t,   8'h00);
    check("tr_rst_edge_chg", chg_t, 8'h00);

    // Bypass: d appears on q with no edge.
    rst_t = 1'b0; en_t = 1'b1; d_t = 8'hA5;
    #1;
    check("tr_bypass_q",    q_t,    8'hA5);
    check("tr_bypass_qbar", qbar_t, 8'h5A);
    tick();
    check("tr_cap_q",   q_t,   8'hA5);
    check("tr_cap_chg", chg_t, 8'h01);

    // en low: q holds A5 while d moves.
    en_t = 1'b0; d_t = 8'h3C;
    #1;
    check("tr_hold_q", q_t, 8'hA5);
    tick();
    check("tr_hold_edge_q",   q_t,   8'hA5);
    check("tr_hold_edge_chg", chg_t, 8'h00);

    // d change after the last capture edge is visible only until en falls.
    en_t = 1'b1; d_t = 8'h11;
    tick();
    d_t = 8'h22;
    #1;
    check("tr_late_d_q", q_t, 8'h22);
    en_t = 1'b0;
    #1;
    check("tr_en_fall_q",    q_t,    8'h11);
    check("tr_en_fall_qbar", qbar_t, 8'hEE);

    // Reset mid-operation: immediate and after the edge.
    rst_t = 1'b1;
    #1;
    check("tr_midrst_comb_q", q_t, 8'h00);
    tick();
    check("tr_midrst_edge_q", q_t, 8'h00);
    rst_t = 1'b0;
    #1;
    check("tr_after_rst_q", q_t, 8'h00);

    // ---------------- u_wide: WIDTH=8, RESET_VALUE=5A ----------------
    rst_w = 1'b1; en_w = 1'b1; d_w = 8'hFF;
    tick();
    check("wide_rst_q",    q_w,    8'h5A);
    check("wide_rst_qbar", qbar_w, 8'hA5);
    check("wide_rst_chg",  chg_w,  8'h00);

    rst_w = 1'b0;
    tick();
    check("wide_cap_q",    q_w,    8'hFF);
    check("wide_cap_qbar", qbar_w, 8'h00);
    check("wide_cap_chg",  chg_w,  8'h01);

    // Changed is a one-cycle pulse.
    en_w = 1'b0; d_w = 8'h00;
    tick();
    check("wide_hold_q",   q_w,   8'hFF);
    check("wide_hold_chg", chg_w, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dlatch_sync.md
Name: dlatch_sync

Overview:
- Enable-gated D storage element, modelled on a classic D latch but built from synchronous, clock-domain-safe logic.
- Captures `d` on rising `clk` while `en` is high and holds otherwise.
- Optional transparent mode lets `q` follow `d` combinationally while `en` is high, giving latch-like output timing without an inferred latch.
- Used as a generic holding register for control and data bits inside a single clock domain.

Parameters:
- WIDTH, 1, data width of `d`, `q` and `qbar`.
- RESET_VALUE, 0 (WIDTH bits), value loaded into storage on reset.
- TRANSPARENT, 0, 0 = edge-captured output (q is the register), 1 = latch-style output (q bypasses the register while `en`=1).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  capture / transparency enable.
- d  input  WIDTH  data in.
- q  output  WIDTH  stored (or bypassed) data.
- qbar  output  WIDTH  bitwise inverse of `q`, always exactly ~q.
- changed  output  1  registered one-cycle pulse: the stored value differed after the last edge.

Behaviour:
- Interface (already decided): one clock `clk`; reset `rst` is synchronous and active-high.
- Single internal register `store[WIDTH-1:0]` plus a 1-bit `changed` register. No other state.
- At each rising `clk`, with priority top to bottom:
  - rst=1: store <= RESET_VALUE; changed <= 0.
  - rst=0, en=1: store <= d; changed <= (d != store).
  - rst=0, en=0: store holds; changed <= 0.
- `rst` overrides `en` when both are high in the same cycle.
- Output q, TRANSPARENT=0:
  - q = store.
  - Latency d->q is 1 edge.
- Output q, TRANSPARENT=1:
  - q = rst ? RESET_VALUE : (en ? d : store), fully combinational.
  - While en=1, d changes appear on q with no clock latency.
  - When en falls, q holds the value captured at the last edge where en=1. A d change after that edge with en still high is visible only until en falls.
- Output qbar:
  - qbar = ~q in both modes.
  - No glitch-free guarantee in transparent mode beyond the combinational path.
- Pre-reset state:
  - Before the first reset or capture, store is undefined (X in simulation).
  - No initial value is assumed. Benches must reset or capture before checking.
- Reset mid-operation:
  - Takes effect at the next rising edge regardless of `en` or `d`.
  - In TRANSPARENT=1, q shows RESET_VALUE combinationally as soon as rst=1.
- Timing:
  - `d` and `en` are sampled only at rising `clk`; mid-cycle activity affects q only in TRANSPARENT=1.
  - No multicycle paths.
  - `en` held high continuously makes the block a plain D flip-flop (mode 0) or a wire plus register (mode 1).
- Widths: all operations are bitwise over WIDTH; no arithmetic, no wrap-around.

Test Plan:
- Reset: rst=1 for one edge with en=1, d=1 -> q=0, qbar=1, changed=0 after the edge (rst beats en).
- Capture: rst=0, en=1, d=1 at an edge -> q=1, qbar=0, changed=1. Next edge with d=0, en=1 -> q=0, changed=1.
- Hold: en=0, d toggled 1/0 across 3 edges after q=0 -> q stays 0, changed=0 throughout.
- No-change capture: en=1, d=0 with store=0 -> q=0, changed=0.
- Transparent mode (TRANSPARENT=1, WIDTH=8):
  - en=1, d=8'hA5 mid-cycle -> q=8'hA5 immediately.
  - Edge, then en=0 with d=8'h3C -> q stays 8'hA5.
  - rst=1 -> q=RESET_VALUE immediately, and after the edge as well.
- Wide reset value (WIDTH=8, RESET_VALUE=8'h5A): reset -> q=8'h5A, qbar=8'hA5. Then en=1, d=8'hFF -> q=8'hFF, changed=1.
